// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Drives one shared external hex decoder and double-buffers the displayed value to frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic                    lz_suppress,
    output logic [3:0]              dec_nibble,
    input  logic [6:0]              dec_seg_n,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    // state | meaning
    // IDLE  | display dark, idx held at 0, pending value may transfer
    // BLANK | all anodes off while seg_n settles on digit idx
    // DRIVE | anode idx on (unless digit idx is blanked)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam int MAXC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] SLOT_TC  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, active_val_q;
    logic [NUM_DIGITS-1:0]   shadow_mask_q, active_mask_q;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   blanked;
    logic                    all_zero;
    logic                    transfer;
    logic                    frame_end;
    logic                    accept;

    assign load_ready = ~pending_q;
    assign accept     = load_valid & ~pending_q;
    assign dec_nibble = active_val_q[{idx_q, 2'b00} +: 4];
    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign frame_done = frame_end;

    // Zero suppression walks down from the most significant digit; digit 0 is always shown.
    always_comb begin
        blanked  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (active_val_q[4*i +: 4] == 4'd0);
            blanked[i] = active_mask_q[i] | (lz_suppress & (i != 0) & all_zero);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CW'(1);
        transfer  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d    = '0;
                cnt_d    = '0;
                transfer = pending_q;
                if (enable) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_TC) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == SLOT_TC) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                        transfer  = pending_q;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
        // Disable aborts the frame: no frame_done, and any transfer waits for IDLE.
        if (!enable) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            frame_end = 1'b0;
            if (state_q != S_IDLE) begin
                transfer = 1'b0;
            end
        end
    end

    always_comb begin
        an_d = '1;
        if (state_d == S_DRIVE && !blanked[idx_d]) begin
            an_d[idx_d] = 1'b0;
        end
        seg_d = (state_d == S_IDLE || blanked[idx_q]) ? 7'h7F : dec_seg_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            shadow_val_q  <= '0;
            shadow_mask_q <= '0;
            active_val_q  <= '0;
            active_mask_q <= '0;
            seg_q         <= 7'h7F;
            an_q          <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            if (accept) begin
                shadow_val_q  <= load_value;
                shadow_mask_q <= load_blank;
                pending_q     <= 1'b1;
            end else if (transfer) begin
                pending_q <= 1'b0;
            end
            if (transfer) begin
                active_val_q  <= shadow_val_q;
                active_mask_q <= shadow_mask_q;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected frames are queued by the stimulus
// and checked position-by-position by a monitor at every frame_done pulse.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0;
    logic [3:0]  load_blank = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  dec_nibble;
    logic [6:0]  dec_seg_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_blank (load_blank),
        .lz_suppress(lz_suppress),
        .dec_nibble (dec_nibble),
        .dec_seg_n  (dec_seg_n),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Shared hex decoder, active-low gfedcba.
    always_comb begin
        case (dec_nibble)
            4'h0: dec_seg_n = 7'h40;  4'h1: dec_seg_n = 7'h79;
            4'h2: dec_seg_n = 7'h24;  4'h3: dec_seg_n = 7'h30;
            4'h4: dec_seg_n = 7'h19;  4'h5: dec_seg_n = 7'h12;
            4'h6: dec_seg_n = 7'h02;  4'h7: dec_seg_n = 7'h78;
            4'h8: dec_seg_n = 7'h00;  4'h9: dec_seg_n = 7'h10;
            4'hA: dec_seg_n = 7'h08;  4'hB: dec_seg_n = 7'h03;
            4'hC: dec_seg_n = 7'h46;  4'hD: dec_seg_n = 7'h21;
            4'hE: dec_seg_n = 7'h06;  default: dec_seg_n = 7'h0E;
        endcase
    end

    typedef struct packed {
        logic [3:0]  lit;
        logic [27:0] seg;
    } exp_t;

    exp_t       exq[$];
    logic [3:0] an_log[64];
    logic [6:0] seg_log[64];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] lit, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        e.lit = lit;
        e.seg = {s3, s2, s1, s0};
        exq.push_back(e);
    endtask

    // Frame layout: digit d occupies positions 6d..6d+1 (blank) and 6d+2..6d+5 (drive).
    task automatic monitor_task();
        int         pos;
        exp_t       e;
        logic [3:0] ea, an_act, gap_act;
        logic [6:0] es, seg_act;
        pos = 0;
        forever begin
            @(negedge clk);
            an_log[pos]  = an_n;
            seg_log[pos] = seg_n;
            if (frame_done) begin
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    chk("frame_length", pos, 23);
                    for (int d = 0; d < N; d++) begin
                        ea = 4'hF;
                        if (e.lit[d]) ea[d] = 1'b0;
                        es      = e.seg[7*d +: 7];
                        an_act  = ea;
                        seg_act = es;
                        gap_act = 4'hF;
                        for (int p = 6*d + 2; p <= 6*d + 5; p++) begin
                            if (an_log[p] !== ea && an_act === ea) an_act = an_log[p];
                            if (seg_log[p] !== es && seg_act === es) seg_act = seg_log[p];
                        end
                        for (int p = 6*d; p <= 6*d + 1; p++) begin
                            if (an_log[p] !== 4'hF && gap_act === 4'hF) gap_act = an_log[p];
                        end
                        chk($sformatf("digit%0d_anode", d), an_act, ea);
                        chk($sformatf("digit%0d_seg", d), seg_act, es);
                        chk($sformatf("digit%0d_gap", d), gap_act, 4'hF);
                    end
                end
                pos = 0;
            end else if (pos < 63) begin
                pos++;
            end
        end
    endtask

    task automatic wait_boundary();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++;
            failures++;
            $display("FAIL boundary_timeout: got no frame_done required a pulse within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] mask);
        int n;
        load_value = val;
        load_blank = mask;
        load_valid = 1'b1;
        n = 0;
        while (!load_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!load_ready) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: got load_ready=0 required 1 within 200 cycles");
        end else begin
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
    endtask

    initial begin
        int  n;
        int  fdcount;
        logic early;

        fork
            monitor_task();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg_n", seg_n, 7'h7F);
        chk("reset_an_n", an_n, 4'hF);
        chk("reset_dec_nibble", dec_nibble, 4'h0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_load_ready", load_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic scan of 12AF.
        do_load(16'h12AF, 4'h0);
        enable = 1'b1;
        wait_boundary();
        push_exp(4'hF, 7'h79, 7'h24, 7'h08, 7'h0E);
        wait_boundary();
        push_exp(4'hF, 7'h79, 7'h24, 7'h08, 7'h0E);
        wait_boundary();

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        do_load(16'h0040, 4'h0);
        wait_boundary();
        push_exp(4'b0011, 7'h7F, 7'h7F, 7'h19, 7'h40);
        wait_boundary();
        do_load(16'h0000, 4'h0);
        wait_boundary();
        push_exp(4'b0001, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        wait_boundary();

        // Double load: second offer stalls until the frame boundary.
        lz_suppress = 1'b0;
        do_load(16'h1111, 4'h0);
        load_value = 16'h2222;
        load_valid = 1'b1;
        chk("ready_low_after_accept", load_ready, 1'b0);
        early = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!frame_done && load_ready) early = 1'b1;
        end while (!frame_done && n < 200);
        chk("boundary_seen", frame_done, 1'b1);
        chk("ready_stalled_until_boundary", early, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_after_boundary", load_ready, 1'b1);
        push_exp(4'hF, 7'h79, 7'h79, 7'h79, 7'h79);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("second_value_accepted", load_ready, 1'b0);
        wait_boundary();
        push_exp(4'hF, 7'h24, 7'h24, 7'h24, 7'h24);
        wait_boundary();

        // Drop enable during digit 2 drive.
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk("digit2_driving", an_n, 4'b1011);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("disable_an_dark", an_n, 4'hF);
        chk("disable_seg_dark", seg_n, 7'h7F);
        fdcount = 0;
        if (frame_done) fdcount++;
        repeat (30) begin
            @(negedge clk);
            if (frame_done) fdcount++;
        end
        chk("aborted_no_frame_done", fdcount, 0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("reenable_blank_c1", an_n, 4'hF);
        @(posedge clk);
        #1;
        chk("reenable_blank_c2", an_n, 4'hF);
        @(posedge clk);
        #1;
        chk("reenable_digit0", an_n, 4'b1110);
        chk("reenable_digit0_seg", seg_n, 7'h24);

        // Per-digit blank mask.
        do_load(16'h8888, 4'b0101);
        wait_boundary();
        push_exp(4'b1010, 7'h00, 7'h7F, 7'h00, 7'h7F);
        wait_boundary();

        // Asynchronous reset mid-drive with a pending load.
        do_load(16'h5555, 4'h0);
        n = 0;
        while (an_n === 4'hF && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drive_reached_before_reset", (an_n !== 4'hF), 1'b1);
        chk("pending_before_reset", load_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_seg_n", seg_n, 7'h7F);
        chk("async_reset_an_n", an_n, 4'hF);
        chk("async_reset_dec_nibble", dec_nibble, 4'h0);
        chk("async_reset_frame_done", frame_done, 1'b0);
        chk("async_reset_load_ready", load_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_boundary();
        push_exp(4'hF, 7'h40, 7'h40, 7'h40, 7'h40);
        wait_boundary();
        chk("ready_after_reset", load_ready, 1'b1);

        chk("scoreboard_drained", exq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
